// File: rtl/i2c_pkg.sv
// Shared encodings for the I2C bit-level controller.
// Holds the command codes carried on Cmd and the phase FSM state encoding.
// No ports; imported by i2c_bit_ctrl.
package i2c_pkg;

   typedef enum logic [1:0] {
      CMD_START = 2'b00,
      CMD_STOP  = 2'b01,
      CMD_WRITE = 2'b10,
      CMD_READ  = 2'b11
   } cmd_e;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PH_A = 3'd1,
      PH_B = 3'd2,
      PH_C = 3'd3,
      PH_D = 3'd4
   } state_e;

endpackage

// File: rtl/i2c_bit_ctrl.sv
// I2C bit controller: runs one START/STOP/WRITE/READ bit as four Tick-paced
// phases and drives the open-drain SCL/SDA controls from registers.
// Ports: Clk/Rst (async active-high); Cmd, Cmd_valid, Din command request
// (taken only while Busy=0); Tick phase pulse and Sda_i line level in;
// Timer_start/Timer_stop pulses to the external bit timer; Scl_o/Sda_o line
// controls (1 = release); Busy, Cmd_ack completion pulse, Dout read bit.
module i2c_bit_ctrl
   import i2c_pkg::*;
(
   input  logic       Clk,
   input  logic       Rst,
   input  logic [1:0] Cmd,
   input  logic       Cmd_valid,
   input  logic       Din,
   input  logic       Tick,
   input  logic       Sda_i,
   output logic       Timer_start,
   output logic       Timer_stop,
   output logic       Scl_o,
   output logic       Sda_o,
   output logic       Busy,
   output logic       Cmd_ack,
   output logic       Dout
);

   state_e state, state_next;
   cmd_e   cmd_q, cmd_next;
   logic   din_q, din_next;
   logic   scl_next, sda_next;
   logic   busy_next, ack_next, dout_next;
   logic   tstart_next, tstop_next;
   logic   enter;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state       <= IDLE;
         cmd_q       <= CMD_START;
         din_q       <= 1'b0;
         Scl_o       <= 1'b1;
         Sda_o       <= 1'b1;
         Busy        <= 1'b0;
         Cmd_ack     <= 1'b0;
         Dout        <= 1'b0;
         Timer_start <= 1'b0;
         Timer_stop  <= 1'b0;
      end else begin
         state       <= state_next;
         cmd_q       <= cmd_next;
         din_q       <= din_next;
         Scl_o       <= scl_next;
         Sda_o       <= sda_next;
         Busy        <= busy_next;
         Cmd_ack     <= ack_next;
         Dout        <= dout_next;
         Timer_start <= tstart_next;
         Timer_stop  <= tstop_next;
      end
   end

   always_comb begin
      state_next  = state;
      cmd_next    = cmd_q;
      din_next    = din_q;
      scl_next    = Scl_o;
      sda_next    = Sda_o;
      busy_next   = Busy;
      ack_next    = 1'b0;
      dout_next   = Dout;
      tstart_next = 1'b0;
      tstop_next  = 1'b0;
      enter       = 1'b0;

      case (state)
         IDLE: begin
            // Busy is still high during the ack cycle, which blocks a
            // request arriving in that cycle. Tick is meaningless here.
            if (Cmd_valid && !Busy) begin
               cmd_next    = cmd_e'(Cmd);
               din_next    = Din;
               state_next  = PH_A;
               tstart_next = 1'b1;
               busy_next   = 1'b1;
               enter       = 1'b1;
            end else begin
               busy_next = 1'b0;
            end
         end
         PH_A: if (Tick) begin
            state_next = PH_B;
            enter      = 1'b1;
         end
         PH_B: if (Tick) begin
            state_next = PH_C;
            enter      = 1'b1;
         end
         PH_C: if (Tick) begin
            state_next = PH_D;
            enter      = 1'b1;
            // SDA is sampled at the end of the SCL-high window.
            if (cmd_q == CMD_READ) dout_next = Sda_i;
         end
         PH_D: if (Tick) begin
            // Back to IDLE; lines keep their PH_D levels until the next
            // command enters PH_A.
            state_next = IDLE;
            ack_next   = 1'b1;
            tstop_next = 1'b1;
         end
         default: state_next = IDLE;
      endcase

      // Line levels are decoded from the phase being entered so the
      // registered outputs change in the first cycle of each phase.
      if (enter) begin
         case (cmd_next)
            CMD_START: begin
               case (state_next)
                  PH_A, PH_B: {scl_next, sda_next} = 2'b11;
                  PH_C:       {scl_next, sda_next} = 2'b10;
                  default:    {scl_next, sda_next} = 2'b00;
               endcase
            end
            CMD_STOP: begin
               case (state_next)
                  PH_A:       {scl_next, sda_next} = 2'b00;
                  PH_B, PH_C: {scl_next, sda_next} = 2'b10;
                  default:    {scl_next, sda_next} = 2'b11;
               endcase
            end
            CMD_WRITE: begin
               scl_next = (state_next == PH_B) || (state_next == PH_C);
               sda_next = din_next;
            end
            default: begin
               scl_next = (state_next == PH_B) || (state_next == PH_C);
               sda_next = 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_bit_ctrl.sv
module tb_i2c_bit_ctrl;
   import i2c_pkg::*;

   logic       Clk = 1'b0;
   logic       Rst;
   logic [1:0] Cmd;
   logic       Cmd_valid;
   logic       Din;
   logic       Tick;
   logic       Sda_i;
   logic       Timer_start;
   logic       Timer_stop;
   logic       Scl_o;
   logic       Sda_o;
   logic       Busy;
   logic       Cmd_ack;
   logic       Dout;

   int n_cmp = 0;
   int n_err = 0;

   i2c_bit_ctrl dut (
      .Clk         (Clk),
      .Rst         (Rst),
      .Cmd         (Cmd),
      .Cmd_valid   (Cmd_valid),
      .Din         (Din),
      .Tick        (Tick),
      .Sda_i       (Sda_i),
      .Timer_start (Timer_start),
      .Timer_stop  (Timer_stop),
      .Scl_o       (Scl_o),
      .Sda_o       (Sda_o),
      .Busy        (Busy),
      .Cmd_ack     (Cmd_ack),
      .Dout        (Dout)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic got, input logic exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, got, exp);
      end
   endtask

   task automatic chk2(input string tag, input logic [1:0] got, input logic [1:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed scl/sda %b expected %b", tag, got, exp);
      end
   endtask

   // Advance to the next rising edge and settle at posedge + 2.
   task automatic cyc();
      @(posedge Clk);
      #2;
   endtask

   // Issue one command and walk it through its four phases with Tick every
   // 4 cycles. exp packs the expected {scl,sda} pairs for phases A,B,C,D.
   // hold keeps Cmd_valid asserted with Cmd=STOP/Din=0 after acceptance.
   task automatic run_cmd(input string nm, input logic [1:0] c, input logic d,
                          input logic si, input logic [7:0] exp, input logic hold);
      Cmd       = c;
      Din       = d;
      Cmd_valid = 1'b1;
      Sda_i     = si;
      Tick      = 1'b1;           // coincides with acceptance, must be ignored
      cyc();
      chk({nm, "_tstart"}, Timer_start, 1'b1);
      chk({nm, "_busy_a"}, Busy, 1'b1);
      chk2({nm, "_ph_a"}, {Scl_o, Sda_o}, exp[7:6]);
      Tick = 1'b0;
      if (hold) begin
         Cmd = CMD_STOP;
         Din = 1'b0;
      end else begin
         Cmd_valid = 1'b0;
      end
      for (int ph = 0; ph < 4; ph++) begin
         for (int k = 0; k < 3; k++) begin
            cyc();
            chk2({nm, "_hold"}, {Scl_o, Sda_o}, exp[7-2*ph -: 2]);
            chk({nm, "_tstart_lo"}, Timer_start, 1'b0);
            chk({nm, "_busy"}, Busy, 1'b1);
         end
         Tick = 1'b1;
         cyc();
         Tick = 1'b0;
         if (ph < 3) begin
            chk2({nm, "_enter"}, {Scl_o, Sda_o}, exp[5-2*ph -: 2]);
            chk({nm, "_ack_lo"}, Cmd_ack, 1'b0);
         end else begin
            chk({nm, "_ack"}, Cmd_ack, 1'b1);
            chk({nm, "_tstop"}, Timer_stop, 1'b1);
            chk({nm, "_busy_ack"}, Busy, 1'b1);
            chk({nm, "_tstart_ack"}, Timer_start, 1'b0);
            chk2({nm, "_ack_lines"}, {Scl_o, Sda_o}, exp[1:0]);
         end
      end
      cyc();
      chk({nm, "_ack_done"}, Cmd_ack, 1'b0);
      chk({nm, "_busy_done"}, Busy, 1'b0);
      chk({nm, "_tstop_lo"}, Timer_stop, 1'b0);
      chk({nm, "_no_restart"}, Timer_start, 1'b0);
      chk2({nm, "_idle_lines"}, {Scl_o, Sda_o}, exp[1:0]);
   endtask

   initial begin
      Rst       = 1'b1;
      Cmd       = 2'b00;
      Cmd_valid = 1'b0;
      Din       = 1'b0;
      Tick      = 1'b0;
      Sda_i     = 1'b1;
      cyc();
      cyc();
      chk2("rst_lines", {Scl_o, Sda_o}, 2'b11);
      chk("rst_busy", Busy, 1'b0);
      chk("rst_ack", Cmd_ack, 1'b0);
      chk("rst_dout", Dout, 1'b0);
      chk("rst_tstart", Timer_start, 1'b0);
      chk("rst_tstop", Timer_stop, 1'b0);
      Rst = 1'b0;
      cyc();

      // Tick pulses with nothing to do.
      for (int i = 0; i < 3; i++) begin
         Tick = 1'b1;
         cyc();
         Tick = 1'b0;
         chk2("idle_tick_lines", {Scl_o, Sda_o}, 2'b11);
         chk("idle_tick_tstart", Timer_start, 1'b0);
         chk("idle_tick_busy", Busy, 1'b0);
         cyc();
         cyc();
         cyc();
      end

      run_cmd("start", CMD_START, 1'b0, 1'b1, 8'b11_11_10_00, 1'b0);

      // Back-to-back writes; Sda_i toggles but must not matter.
      run_cmd("wr0", CMD_WRITE, 1'b0, 1'b1, 8'b00_10_10_00, 1'b0);
      run_cmd("wr1", CMD_WRITE, 1'b1, 1'b0, 8'b01_11_11_01, 1'b0);
      chk("wr_dout_held", Dout, 1'b0);

      run_cmd("rd0", CMD_READ, 1'b1, 1'b0, 8'b01_11_11_01, 1'b0);
      chk("rd0_dout", Dout, 1'b0);
      run_cmd("rd1", CMD_READ, 1'b0, 1'b1, 8'b01_11_11_01, 1'b0);
      chk("rd1_dout", Dout, 1'b1);

      // STOP request held through an active WRITE, taken after the ack.
      run_cmd("wr_hold", CMD_WRITE, 1'b1, 1'b0, 8'b01_11_11_01, 1'b1);
      run_cmd("stop", CMD_STOP, 1'b0, 1'b0, 8'b00_10_10_11, 1'b0);
      chk("stop_dout_held", Dout, 1'b1);

      // Reset in PH_B of a READ.
      Cmd       = CMD_READ;
      Cmd_valid = 1'b1;
      Sda_i     = 1'b0;
      cyc();
      Cmd_valid = 1'b0;
      chk("rr_busy", Busy, 1'b1);
      chk2("rr_ph_a", {Scl_o, Sda_o}, 2'b01);
      cyc();
      cyc();
      cyc();
      Tick = 1'b1;
      cyc();
      Tick = 1'b0;
      chk2("rr_ph_b", {Scl_o, Sda_o}, 2'b11);
      chk("rr_dout_before", Dout, 1'b1);
      #1 Rst = 1'b1;
      #1;
      chk2("rr_lines", {Scl_o, Sda_o}, 2'b11);
      chk("rr_busy_rst", Busy, 1'b0);
      chk("rr_ack_rst", Cmd_ack, 1'b0);
      chk("rr_dout_rst", Dout, 1'b0);
      chk("rr_tstart_rst", Timer_start, 1'b0);
      chk("rr_tstop_rst", Timer_stop, 1'b0);
      cyc();
      Rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         Tick = 1'b1;
         cyc();
         Tick = 1'b0;
         chk("rr_no_ack", Cmd_ack, 1'b0);
         chk("rr_idle_busy", Busy, 1'b0);
      end

      run_cmd("start2", CMD_START, 1'b0, 1'b1, 8'b11_11_10_00, 1'b0);
      chk("start2_dout", Dout, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/i2c_bit_ctrl.md
I2C_BIT_CTRL -- requirements
Module: i2c_bit_ctrl

Interface
REQ-001 Parameters: none; the command and phase encodings come from the shared package.
REQ-002 Clk  in  1  single system clock; all state updates on rising edge.
REQ-003 Rst  in  1  reset, asynchronous, active-high.
REQ-004 Cmd  in  2  command code: 00 START, 01 STOP, 10 WRITE, 11 READ.
REQ-005 Cmd_valid  in  1  command request; sampled only when Busy=0.
REQ-006 Din  in  1  bit to transmit for WRITE; sampled with Cmd.
REQ-007 Tick  in  1  one-cycle phase pulse from i2c_bit_timer Out.
REQ-008 Sda_i  in  1  SDA line level, already synchronised externally.
REQ-009 Timer_start  out  1  one-cycle pulse that loads and starts i2c_bit_timer.
REQ-010 Timer_stop  out  1  one-cycle pulse that halts i2c_bit_timer.
REQ-011 Scl_o  out  1  SCL open-drain control: 0 drives low, 1 releases.
REQ-012 Sda_o  out  1  SDA open-drain control: 0 drives low, 1 releases.
REQ-013 Busy  out  1  high from the cycle after acceptance until the Cmd_ack cycle, inclusive.
REQ-014 Cmd_ack  out  1  one-cycle pulse when a command completes.
REQ-015 Dout  out  1  bit sampled by the last READ; holds its value until the next READ samples.

Function
REQ-016 FSM states: IDLE, PH_A, PH_B, PH_C, PH_D.
REQ-017 In IDLE with Cmd_valid=1, latch Cmd/Din, go to PH_A next cycle, and pulse Timer_start in that same next cycle.
REQ-018 In PH_A/B/C, a Tick pulse advances to the next phase; without Tick the state holds indefinitely.
REQ-019 In PH_D, Tick causes a return to IDLE, plus a one-cycle Cmd_ack and one-cycle Timer_stop in the following cycle.
REQ-020 A command therefore lasts exactly 4 Tick pulses plus 2 cycles of acceptance/ack overhead.
REQ-021 Scl_o/Sda_o per phase A,B,C,D, registered and updated on phase entry:
- START: (1,1)(1,1)(1,0)(0,0)
- STOP: (0,0)(1,0)(1,0)(1,1)
- WRITE: (0,Din)(1,Din)(1,Din)(0,Din)
- READ: (0,1)(1,1)(1,1)(0,1)
REQ-022 READ: Dout loads Sda_i on the Tick that ends PH_C.
REQ-023 In IDLE, Scl_o/Sda_o hold the PH_D values of the last command (1,1 after reset).
REQ-024 Cmd_valid while Busy=1 is ignored: not queued, and the latched Cmd/Din are unchanged.
REQ-025 Tick in IDLE is ignored.
REQ-026 Tick arriving in the same cycle as acceptance is ignored.
REQ-027 Cmd_valid in the Cmd_ack cycle is ignored because Busy=1; it is accepted the next cycle if still asserted.
REQ-028 Timer_start and Timer_stop are never high in the same cycle.

Reset
REQ-029 Rst=1 forces, immediately and asynchronously:
- state IDLE
- Scl_o=1, Sda_o=1
- Busy=0, Cmd_ack=0, Dout=0
- Timer_start=0, Timer_stop=0
REQ-030 Reset mid-command aborts the command without Cmd_ack; the first Cmd_valid after release is accepted normally.

Structure
REQ-031 Shared package i2c_pkg: command codes (CMD_START, CMD_STOP, CMD_WRITE, CMD_READ) and FSM state encodings.
REQ-032 No sub-module: phase-to-line decoding is a single registered case inside the block.
REQ-033 i2c_bit_timer is instantiated by the parent, not inside this block.

Verification
REQ-034 Bench drives Tick every 4 cycles; the check point is posedge + 2 time units.
REQ-035 START accepted -> Timer_start at +1 cycle; Scl_o/Sda_o sequence 11,11,10,00; Cmd_ack 1 cycle after 4th Tick; Busy=0 afterwards.
REQ-036 WRITE Din=0 then WRITE Din=1 back-to-back -> Sda_o constant per command (0 then 1); Scl_o 0,1,1,0 each; two Cmd_ack pulses.
REQ-037 READ with Sda_i=0 during PH_C -> Dout=0; READ with Sda_i=1 -> Dout=1; Sda_o stays 1 throughout.
REQ-038 Cmd_valid=1 with Cmd=STOP held during an active WRITE -> WRITE completes unchanged, STOP accepted in the cycle after Cmd_ack; STOP ends with Scl_o=1, Sda_o=1.
REQ-039 Rst asserted in PH_B of READ -> same-cycle Scl_o=1, Sda_o=1, Busy=0, no Cmd_ack, Dout=0.
REQ-040 Tick pulses with no command -> no output change, no Timer_start, errors=0.
